// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS datapath (FFT output bus and analysis stage).
package fas_pkg;

  localparam int FFT_DW   = 16;
  localparam int FFT_NBIN = 16;
  localparam int MAG_W    = 2 * FFT_DW + 1;

  typedef enum logic [1:0] {
    ANA_IDLE,
    ANA_SCAN,
    ANA_DONE
  } ana_state_t;

  // Packs as {re, im}, matching the bit order of one bin on the FFT output bus.
  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } fft_bin_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude re*re + im*im of one complex bin.
module fft_mag_sq #(
  parameter int DW = 16
) (
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  output logic        [2*DW:0] mag
);

  logic signed [2*DW-1:0] re_sq;
  logic signed [2*DW-1:0] im_sq;

  assign re_sq = re * re;
  assign im_sq = im * im;

  // Each square is non-negative; one extra bit keeps (-2^(DW-1))^2 * 2 from wrapping.
  assign mag = {1'b0, re_sq} + {1'b0, im_sq};

endmodule

// File: rtl/fft_peak_analyzer.sv
// Captures a complex FFT frame and scans it one bin per cycle for the peak magnitude.
// Build option FFT_HALF_SPECTRUM_EN: capture and scan only bins 0..7.
module fft_peak_analyzer
  import fas_pkg::*;
#(
  parameter int DW = FFT_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            busy,
  output logic            done,
  output logic [3:0]      freq,
  output logic            overrun,
  output ana_state_t      dbg_state
);

`ifdef FFT_HALF_SPECTRUM_EN
  localparam int NSCAN = FFT_NBIN / 2;
`else
  localparam int NSCAN = FFT_NBIN;
`endif
  localparam int               IDX_W = $clog2(NSCAN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NSCAN - 1);

  // Handshake: fft_valid is a one-cycle strobe with no ready; a frame is taken
  // only in IDLE or DONE, and a strobe seen in SCAN is dropped and flagged.

  logic [2*DW-1:0] fft_d [FFT_NBIN];
  assign fft_d = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  ana_state_t state, state_nxt;
  logic       accept;

  logic signed [DW-1:0] buf_re [NSCAN];
  logic signed [DW-1:0] buf_im [NSCAN];
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     max_idx;
  logic [2*DW:0]        max_mag;
  logic [2*DW:0]        mag;
  logic                 mag_gt;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ANA_IDLE: begin
        if (fft_valid) begin
          accept    = 1'b1;
          state_nxt = ANA_SCAN;
        end
      end
      ANA_SCAN: begin
        if (idx == LAST) state_nxt = ANA_DONE;
      end
      ANA_DONE: begin
        accept    = fft_valid;
        state_nxt = fft_valid ? ANA_SCAN : ANA_IDLE;
      end
      default: state_nxt = ANA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ANA_IDLE;
    else      state <= state_nxt;
  end

  // Buffer contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NSCAN; i++) begin
        buf_re[i] <= fft_d[i][2*DW-1:DW];
        buf_im[i] <= fft_d[i][DW-1:0];
      end
    end
  end

  fft_mag_sq #(.DW(DW)) u_mag (
    .re  (buf_re[idx]),
    .im  (buf_im[idx]),
    .mag (mag)
  );

  // Strict compare: on equal magnitudes the earlier (lower) bin wins.
  assign mag_gt = (mag > max_mag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      max_idx <= '0;
      max_mag <= '0;
      freq    <= '0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        idx     <= '0;
        max_idx <= '0;
        max_mag <= '0;
      end else if (state == ANA_SCAN) begin
        if (mag_gt) begin
          max_mag <= mag;
          max_idx <= idx;
        end
        if (idx == LAST) freq <= 4'(mag_gt ? idx : max_idx);
        else             idx  <= idx + 1'b1;
      end
      if ((state == ANA_SCAN) && fft_valid) overrun <= 1'b1;
    end
  end

  assign busy      = (state == ANA_SCAN);
  assign done      = (state == ANA_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Self-checking bench for fft_peak_analyzer: directed spec cases plus random frames vs. an argmax model.
module tb_fft_peak_analyzer;
  import fas_pkg::*;

`ifdef FFT_HALF_SPECTRUM_EN
  localparam int NSCAN = 8;
`else
  localparam int NSCAN = 16;
`endif
  localparam int LAT_EXP = NSCAN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fft_valid = 1'b0;
  fft_bin_t   frame [FFT_NBIN];
  logic       busy, done, overrun;
  logic [3:0] freq;
  ana_state_t dbg_state;

  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  fft_peak_analyzer dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(frame[0]),   .fft_d1(frame[1]),   .fft_d2(frame[2]),   .fft_d3(frame[3]),
    .fft_d4(frame[4]),   .fft_d5(frame[5]),   .fft_d6(frame[6]),   .fft_d7(frame[7]),
    .fft_d8(frame[8]),   .fft_d9(frame[9]),   .fft_d10(frame[10]), .fft_d11(frame[11]),
    .fft_d12(frame[12]), .fft_d13(frame[13]), .fft_d14(frame[14]), .fft_d15(frame[15]),
    .busy(busy), .done(done), .freq(freq), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: index of the largest re^2+im^2 among scanned bins, lowest index on ties.
  function automatic logic [3:0] model_peak();
    longint best = -1;
    logic [3:0] pk = '0;
    for (int k = 0; k < NSCAN; k++) begin
      longint r = longint'($signed(frame[k].re));
      longint m = longint'($signed(frame[k].im));
      longint p = r * r + m * m;
      if (p > best) begin
        best = p;
        pk = 4'(k);
      end
    end
    return pk;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_frame();
    for (int k = 0; k < FFT_NBIN; k++) frame[k] = '0;
  endtask

  task automatic set_bin(input int k, input logic [15:0] re, input logic [15:0] im);
    frame[k].re = re;
    frame[k].im = im;
  endtask

  task automatic rand_frame();
    int mode = int'($urandom_range(0, 2));
    clear_frame();
    for (int k = 0; k < FFT_NBIN; k++) begin
      if (mode == 0) frame[k] = fft_bin_t'($urandom);
      else if (mode == 1) begin
        int a = int'($urandom_range(0, 4));
        int b = int'($urandom_range(0, 4));
        frame[k].re = 16'(a - 2);
        frame[k].im = 16'(b - 2);
      end else if ($urandom_range(0, 3) == 0) frame[k] = fft_bin_t'($urandom);
    end
  endtask

  task automatic scramble_frame();
    for (int k = 0; k < FFT_NBIN; k++) frame[k] = fft_bin_t'($urandom);
  endtask

  // Call at a negedge: strobes the current frame, returns at the next negedge with valid low.
  task automatic start_frame();
    fft_valid = 1'b1;
    @(posedge clk);
    #1 check("busy_scan", busy, 1'b1);
    @(negedge clk);
    fft_valid = 1'b0;
  endtask

  // lat counts negedges after the sample edge; done seen at negedge n means it is sampled at edge n.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_frame(input logic exp_ovr, input int lat);
    check("latency", lat, LAT_EXP);
    check("freq", freq, (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx);
    check("overrun", overrun, exp_ovr);
  endtask

  task automatic run_frame(input logic [3:0] exp_freq, input logic exp_ovr);
    int lat;
    @(negedge clk);
    exp_q.push_back(exp_freq);
    start_frame();
    scramble_frame();
    wait_done(1, lat);
    finish_frame(exp_ovr, lat);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int nd;
    clear_frame();
    repeat (3) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_freq", freq, 4'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ANA_IDLE);
    rst = 1'b1;

    clear_frame(); set_bin(1, 16'h0100, 16'h0000);
    run_frame(4'd1, 1'b0);

    clear_frame(); set_bin(9, 16'h8000, 16'h0000); set_bin(4, 16'h7FFF, 16'h7FFF);
    run_frame(4'd4, 1'b0);

    clear_frame(); set_bin(2, 16'h7FFF, 16'h7FFF); set_bin(6, 16'h8000, 16'h8000);
    run_frame(4'd6, 1'b0);

    clear_frame(); set_bin(3, 16'h0200, 16'hFE00); set_bin(12, 16'h0200, 16'hFE00);
    run_frame(4'd3, 1'b0);

    clear_frame();
    run_frame(4'd0, 1'b0);

    clear_frame(); set_bin(15, 16'h0400, 16'h0000); set_bin(2, 16'h0100, 16'h0000);
`ifdef FFT_HALF_SPECTRUM_EN
    run_frame(4'd2, 1'b0);
`else
    run_frame(4'd15, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      rand_frame();
      run_frame(model_peak(), 1'b0);
    end

    // Back-to-back: second frame strobed in the DONE cycle of the first.
    clear_frame(); set_bin(7, 16'h0000, 16'h0100);
    @(negedge clk);
    exp_q.push_back(4'd7);
    start_frame();
    clear_frame(); set_bin(2, 16'h0300, 16'h0000);
    wait_done(1, lat);
    finish_frame(1'b0, lat);
    exp_q.push_back(model_peak());
    start_frame();
    check("b2b_state", dbg_state, ANA_SCAN);
    wait_done(1, lat);
    finish_frame(1'b0, lat);
    @(negedge clk);
    check("done_pulse_b2b", done, 1'b0);

    // Overrun: a second strobe five cycles into the scan is dropped.
    clear_frame(); set_bin(5, 16'h0100, 16'h0000);
    @(negedge clk);
    exp_q.push_back(4'd5);
    start_frame();
    for (int c = 1; c < 5; c++) @(negedge clk);
    check("overrun_pre", overrun, 1'b0);
    clear_frame(); set_bin(10, 16'h7000, 16'h7000); set_bin(0, 16'h6000, 16'h0000);
    fft_valid = 1'b1;
    @(negedge clk);
    fft_valid = 1'b0;
    check("overrun_set", overrun, 1'b1);
    wait_done(6, lat);
    finish_frame(1'b1, lat);

    for (int i = 0; i < 3; i++) begin
      rand_frame();
      run_frame(model_peak(), 1'b1);
    end

    // Reset eight cycles into a scan.
    clear_frame(); set_bin(3, 16'h0100, 16'h0100);
    @(negedge clk);
    start_frame();
    for (int c = 1; c < 8; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_freq", freq, 4'd0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_rst", nd, 0);

    clear_frame(); set_bin(11, 16'hFF00, 16'h0000); set_bin(6, 16'h0080, 16'h0080);
    run_frame(model_peak(), 1'b0);

    for (int i = 0; i < 15; i++) begin
      rand_frame();
      run_frame(model_peak(), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
